edf_irq_dispatch: RTL and testbench
===================================

EDF_IRQ_DISPATCH -- requirements
Module: edf_irq_dispatch

Interface
REQ-001 SHALL have parameter NrIrqs, default 4, number of interrupt lines; legal range is 2 or more.
REQ-002 SHALL have parameter CntWidth, default 16, width of the latency counter.
REQ-003 SHALL have localparam IdWidth = $clog2(NrIrqs), width of every ID port.
REQ-004 SHALL have ports:
- clk_i  in  1  clock; the only clock; all state on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- irq_valid_i  in  1  upstream EDF controller has an arbitration winner.
- irq_id_i  in  IdWidth  winner ID; valid when irq_valid_i=1.
- irq_ready_o  out  1  acknowledges irq_valid_i; handshake fires when irq_valid_i & irq_ready_o.
- core_irq_o  out  1  interrupt request to core.
- core_irq_id_o  out  IdWidth  ID presented to core.
- core_ack_i  in  1  core takes the presented interrupt.
- core_complete_i  in  1  core signals end of handler.
- core_complete_id_i  in  IdWidth  ID being completed.
- err_clr_i  in  1  clears err_o.
- busy_o  out  1  an interrupt is pending or in service.
- active_id_o  out  IdWidth  ID held by the block.
- err_o  out  1  sticky protocol error.
- lat_cnt_o  out  CntWidth  request-to-ack latency of the last acknowledged interrupt.

Function
REQ-005 SHALL implement a three-state FSM: IDLE, PEND and SERVICE.
REQ-006 irq_ready_o SHALL be 1 exactly when the state is IDLE; it SHALL be a combinational decode of the state register, with no dependence on irq_valid_i.
REQ-007 In IDLE, a handshake SHALL, on that edge:
- register irq_id_i into the held ID;
- clear the latency counter to 0;
- move the FSM to PEND.
REQ-008 irq_id_i SHALL be ignored when no handshake occurs.
REQ-009 In PEND:
- core_irq_o SHALL be 1 and core_irq_id_o SHALL equal the held ID;
- the latency counter SHALL increment by 1 per cycle and saturate at 2^CntWidth-1 (no wrap).
REQ-010 In PEND with core_ack_i=1, on that edge:
- lat_cnt_o SHALL load the current counter value; the counter is 0 in the first PEND cycle;
- the FSM SHALL move to SERVICE.
REQ-011 In SERVICE with core_complete_i=1 and core_complete_id_i equal to the held ID, the FSM SHALL move to IDLE on that edge.
REQ-012 In SERVICE with core_complete_i=1 and a different ID, the FSM SHALL stay in SERVICE and err_o SHALL set.
REQ-013 core_complete_i=1 in IDLE or PEND SHALL set err_o and SHALL NOT change the state.
REQ-014 core_ack_i in IDLE or SERVICE SHALL be ignored.
REQ-015 In PEND, core_ack_i and core_complete_i high together: the ack SHALL be taken (REQ-010), and err_o SHALL set per REQ-013.
REQ-016 err_o is sticky:
- err_clr_i=1 SHALL clear it on the next edge;
- an error event in the same cycle as err_clr_i SHALL win, leaving err_o=1.
REQ-017 busy_o SHALL be 1 in PEND and SERVICE; active_id_o SHALL equal the held ID at all times.
REQ-018 core_irq_o SHALL be 0 outside PEND, and core_irq_id_o SHALL equal the held ID at all times.
REQ-019 The block SHALL add no combinational path from any input to any output except irq_ready_o, which is state-only.
REQ-020 One SERVICE to IDLE transition followed by a new handshake SHALL take at least 1 IDLE cycle; there is no back-to-back bypass.

Reset
REQ-021 rst_ni=0 SHALL immediately force these values, independent of clk_i:
- FSM = IDLE;
- held ID = 0, latency counter = 0;
- irq_ready_o = 1;
- core_irq_o = 0, busy_o = 0;
- err_o = 0, lat_cnt_o = 0;
- core_irq_id_o = 0, active_id_o = 0.
REQ-022 Reset asserted in PEND or SERVICE SHALL abandon the interrupt with no error recorded.
REQ-023 The first handshake SHALL be accepted on the first rising edge after rst_ni deasserts.

Verification
REQ-024 Basic flow:
- Stimulus: irq_valid_i=1, id=2; ack 3 cycles after core_irq_o rises; complete id=2.
- Response: core_irq_o=1 for 3 cycles with id 2; lat_cnt_o=2; busy_o falls after the complete; irq_ready_o=1.
REQ-025 Mismatched complete:
- Stimulus: id 1 in SERVICE; complete id=3.
- Response: err_o=1, still SERVICE; then complete id=1 gives IDLE.
- Stimulus: err_clr_i pulse.
- Response: err_o=0.
REQ-026 Saturation:
- Stimulus: CntWidth=4; ack held off 40 cycles.
- Response: lat_cnt_o=15 after ack.
REQ-027 Stray events:
- Stimulus: complete in IDLE.
- Response: err_o=1, state IDLE.
- Stimulus: ack in IDLE.
- Response: no effect.
- Stimulus: err_clr_i and a stray complete in the same cycle.
- Response: err_o stays 1.
REQ-028 Reset mid-operation:
- Stimulus: rst_ni low asynchronously while in PEND.
- Response: core_irq_o=0 and irq_ready_o=1 without a clock edge; err_o=0.
REQ-029 Backpressure:
- Stimulus: irq_valid_i held 1 with id changing 0 to 3 during PEND/SERVICE.
- Response: held ID unchanged; the next accept captures the id present in the first IDLE cycle.

Source files
------------

// File: rtl/edf_irq_dispatch.sv
// EDF interrupt dispatcher: takes the EDF arbitration winner, presents it
// to the core, measures request-to-ack latency and flags protocol errors.
//
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   irq_valid_i/irq_id_i   winner from the EDF controller
//   irq_ready_o            accept strobe (state-only decode)
//   core_irq_o/_id_o       request and ID presented to the core
//   core_ack_i             core takes the interrupt
//   core_complete_i/_id_i  end of handler and completed ID
//   err_clr_i/err_o        clear and sticky protocol error
//   busy_o/active_id_o     pending/in-service flag and held ID
//   lat_cnt_o              latency of the last acknowledged interrupt
module edf_irq_dispatch #(
  parameter int unsigned NrIrqs   = 4,
  parameter int unsigned CntWidth = 16,
  localparam int unsigned IdWidth = $clog2(NrIrqs)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                irq_valid_i,
  input  logic [IdWidth-1:0]  irq_id_i,
  output logic                irq_ready_o,
  output logic                core_irq_o,
  output logic [IdWidth-1:0]  core_irq_id_o,
  input  logic                core_ack_i,
  input  logic                core_complete_i,
  input  logic [IdWidth-1:0]  core_complete_id_i,
  input  logic                err_clr_i,
  output logic                busy_o,
  output logic [IdWidth-1:0]  active_id_o,
  output logic                err_o,
  output logic [CntWidth-1:0] lat_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IdWidth-1:0]  id_q, id_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [CntWidth-1:0] lat_q, lat_d;
  logic                err_q, err_d;
  logic                id_match;
  logic                err_evt;

  assign id_match = (core_complete_id_i == id_q);

  // Any complete outside SERVICE, or with the wrong ID, is an error.
  assign err_evt = core_complete_i &&
                   ((state_q != SERVICE) || !id_match);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    unique case (state_q)
      IDLE: begin
        if (irq_valid_i) begin
          id_d    = irq_id_i;
          cnt_d   = '0;
          state_d = PEND;
        end
      end
      PEND: begin
        // Saturate rather than wrap so a long stall reads as max.
        if (cnt_q != {CntWidth{1'b1}}) begin
          cnt_d = cnt_q + CntWidth'(1);
        end
        if (core_ack_i) begin
          lat_d   = cnt_q;
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (core_complete_i && id_match) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Error event wins over a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (err_evt) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      id_q    <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
    end
  end

  assign irq_ready_o   = (state_q == IDLE);
  assign core_irq_o    = (state_q == PEND);
  assign busy_o        = (state_q != IDLE);
  assign core_irq_id_o = id_q;
  assign active_id_o   = id_q;
  assign err_o         = err_q;
  assign lat_cnt_o     = lat_q;

endmodule

// File: tb/tb_edf_irq_dispatch.sv
// Self-checking bench for edf_irq_dispatch: a default instance plus a
// CntWidth=4 instance driven in parallel for the saturation case.
module tb_edf_irq_dispatch;

  logic       clk;
  logic       rst_n;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic       core_ack;
  logic       core_complete;
  logic [1:0] core_complete_id;
  logic       err_clr;

  logic        irq_ready, core_irq, busy, err;
  logic [1:0]  core_irq_id, active_id;
  logic [15:0] lat_cnt;

  logic        s_ready, s_irq, s_busy, s_err;
  logic [1:0]  s_irq_id, s_active_id;
  logic [3:0]  s_lat;

  int checks = 0;
  int errors = 0;

  int exp_id_q[$];
  int exp_lat_q[$];
  int exp_sat_q[$];

  edf_irq_dispatch u_dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .irq_valid_i        (irq_valid),
    .irq_id_i           (irq_id),
    .irq_ready_o        (irq_ready),
    .core_irq_o         (core_irq),
    .core_irq_id_o      (core_irq_id),
    .core_ack_i         (core_ack),
    .core_complete_i    (core_complete),
    .core_complete_id_i (core_complete_id),
    .err_clr_i          (err_clr),
    .busy_o             (busy),
    .active_id_o        (active_id),
    .err_o              (err),
    .lat_cnt_o          (lat_cnt)
  );

  edf_irq_dispatch #(.CntWidth(4)) u_sat (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .irq_valid_i        (irq_valid),
    .irq_id_i           (irq_id),
    .irq_ready_o        (s_ready),
    .core_irq_o         (s_irq),
    .core_irq_id_o      (s_irq_id),
    .core_ack_i         (core_ack),
    .core_complete_i    (core_complete),
    .core_complete_id_i (core_complete_id),
    .err_clr_i          (err_clr),
    .busy_o             (s_busy),
    .active_id_o        (s_active_id),
    .err_o              (s_err),
    .lat_cnt_o          (s_lat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic complete(input logic [1:0] id);
    core_complete    = 1'b1;
    core_complete_id = id;
    tick();
    core_complete    = 1'b0;
  endtask

  // Handshake id, hold off ack for dly PEND cycles, then ack.
  task automatic do_irq(input logic [1:0] id, input int dly);
    int n;
    irq_valid = 1'b1;
    irq_id    = id;
    exp_id_q.push_back(int'(id));
    exp_lat_q.push_back(dly);
    exp_sat_q.push_back(dly > 15 ? 15 : dly);
    n = 0;
    while (!irq_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(irq_ready), 32'(1));
    tick();
    irq_valid = 1'b0;
    check("irq_up", 32'(core_irq), 32'(1));
    check("irq_id", 32'(core_irq_id), 32'(exp_id_q.pop_front()));
    repeat (dly) begin
      tick();
      check("irq_held", 32'(core_irq), 32'(1));
    end
    core_ack = 1'b1;
    tick();
    core_ack = 1'b0;
    check("irq_down", 32'(core_irq), 32'(0));
    check("svc_busy", 32'(busy), 32'(1));
    check("lat", 32'(lat_cnt), 32'(exp_lat_q.pop_front()));
    check("lat_sat", 32'(s_lat), 32'(exp_sat_q.pop_front()));
  endtask

  initial begin
    rst_n            = 1'b0;
    irq_valid        = 1'b0;
    irq_id           = 2'd0;
    core_ack         = 1'b0;
    core_complete    = 1'b0;
    core_complete_id = 2'd0;
    err_clr          = 1'b0;

    #23;
    check("rst_ready", 32'(irq_ready), 32'(1));
    check("rst_irq", 32'(core_irq), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_lat", 32'(lat_cnt), 32'(0));
    check("rst_id", 32'(core_irq_id), 32'(0));
    check("rst_act", 32'(active_id), 32'(0));

    // Release, then the first edge must accept.
    tick();
    rst_n = 1'b1;
    do_irq(2'd2, 2);
    check("basic_act", 32'(active_id), 32'(2));
    complete(2'd2);
    check("basic_idle", 32'(busy), 32'(0));
    check("basic_ready", 32'(irq_ready), 32'(1));
    check("basic_err", 32'(err), 32'(0));

    // Mismatched complete.
    do_irq(2'd1, 0);
    complete(2'd3);
    check("mm_err", 32'(err), 32'(1));
    check("mm_busy", 32'(busy), 32'(1));
    check("mm_ready", 32'(irq_ready), 32'(0));
    complete(2'd1);
    check("mm_idle", 32'(busy), 32'(0));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("mm_clr", 32'(err), 32'(0));

    // Stray complete and ack in IDLE.
    complete(2'd0);
    check("stray_err", 32'(err), 32'(1));
    check("stray_ready", 32'(irq_ready), 32'(1));
    core_ack = 1'b1;
    tick();
    core_ack = 1'b0;
    check("ack_idle_busy", 32'(busy), 32'(0));
    check("ack_idle_irq", 32'(core_irq), 32'(0));
    err_clr = 1'b1;
    complete(2'd0);
    err_clr = 1'b0;
    check("clr_vs_evt", 32'(err), 32'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr2", 32'(err), 32'(0));

    // Ack and complete together in PEND.
    irq_valid = 1'b1;
    irq_id    = 2'd3;
    tick();
    irq_valid = 1'b0;
    tick();
    core_ack         = 1'b1;
    core_complete    = 1'b1;
    core_complete_id = 2'd3;
    tick();
    core_ack      = 1'b0;
    core_complete = 1'b0;
    check("ackc_svc", 32'(busy & ~core_irq), 32'(1));
    check("ackc_err", 32'(err), 32'(1));
    check("ackc_lat", 32'(lat_cnt), 32'(1));
    complete(2'd3);
    check("ackc_idle", 32'(busy), 32'(0));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Saturation: 40-cycle stall.
    do_irq(2'd3, 40);
    complete(2'd3);

    // Backpressure: id changes while busy are ignored.
    irq_valid = 1'b1;
    irq_id    = 2'd0;
    tick();
    irq_id = 2'd3;
    tick();
    check("bp_pend", 32'(active_id), 32'(0));
    core_ack = 1'b1;
    tick();
    core_ack = 1'b0;
    irq_id   = 2'd1;
    tick();
    check("bp_svc", 32'(active_id), 32'(0));
    irq_id = 2'd3;
    complete(2'd0);
    check("bp_gap", 32'(irq_ready), 32'(1));
    check("bp_gap_busy", 32'(busy), 32'(0));
    irq_id = 2'd2;
    tick();
    irq_valid = 1'b0;
    check("bp_capture", 32'(active_id), 32'(2));
    check("bp_pend2", 32'(core_irq), 32'(1));

    // Async reset in PEND with a pending error.
    complete(2'd1);
    check("pre_rst_err", 32'(err), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_irq", 32'(core_irq), 32'(0));
    check("arst_ready", 32'(irq_ready), 32'(1));
    check("arst_err", 32'(err), 32'(0));
    check("arst_act", 32'(active_id), 32'(0));
    tick();
    rst_n = 1'b1;
    do_irq(2'd1, 1);
    complete(2'd1);
    check("post_rst_idle", 32'(busy), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
